div_sched: RTL
==============

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter: WIDTH, default 20, bit width of the divide-ratio value and the internal counter.
REQ-002 Port: clock_in  input  1  single clock; all logic on its rising edge.
REQ-003 Port: reset_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  level sampled each cycle; requests IDLE->RUN.
REQ-005 Port: stop  input  1  level sampled each cycle; requests return to IDLE.
REQ-006 Port: cfg_valid  input  1  divide-ratio write request.
REQ-007 Port: cfg_div  input  WIDTH  divide value D; tick period = D+1 cycles.
REQ-008 Port: cfg_ready  output  1  block can accept a cfg write this cycle.
REQ-009 Port: tick  output  1  one-cycle enable pulse at each period end.
REQ-010 Port: clock_out  output  1  divided square wave, toggles on each tick.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, RUN and PEND (RUN with a ratio update queued).
REQ-013 A cfg write SHALL be accepted exactly on a cycle where cfg_valid and cfg_ready are both 1.
REQ-014 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in PEND.
REQ-015 A write accepted in IDLE SHALL load the active ratio register directly; the counter is held at 0.
REQ-016 start=1 in IDLE SHALL enter RUN on the next cycle, with the counter beginning at 0.
REQ-017 In RUN and PEND the counter SHALL increment each cycle from 0 to the active D, then wrap to 0.
REQ-018 tick SHALL be registered and high exactly on the cycles where the counter equals the active D.
REQ-019 With D=0, tick SHALL be high on every RUN cycle.
REQ-020 clock_out SHALL invert on the cycle after each tick, giving a period of 2(D+1) cycles.
REQ-021 A write accepted in RUN SHALL store cfg_div into the pending register and enter PEND.
REQ-022 In PEND, on the first cycle with tick=1, the pending value SHALL become active, the counter SHALL restart at 0 under the new D, and the state SHALL return to RUN.
REQ-023 A write accepted on the same cycle as a tick SHALL take effect at the following tick, not the current one.
REQ-024 stop=1 in RUN or PEND SHALL, on the next cycle, enter IDLE, discard any pending value, clear the counter, and drive tick=0 and clock_out=0.
REQ-025 If start and stop are both 1 in the same cycle, stop SHALL win.
REQ-026 start asserted in RUN or PEND SHALL be ignored.
REQ-027 The counter SHALL be WIDTH bits, and all comparisons SHALL be unsigned.

Reset
REQ-028 While reset_n=0 at a clock edge, the block SHALL set state=IDLE, counter=0, active D = all ones, pending register = 0, tick=0, clock_out=0, busy=0 and cfg_ready=1.
REQ-029 Reset asserted mid-RUN or mid-PEND SHALL abandon the operation, with no tick emitted on the reset cycle.

Configuration
REQ-030 When macro DIV_SCHED_TICKCNT_EN is defined, the block SHALL add output tick_cnt[15:0], which increments on each tick, wraps from 0xFFFF to 0, and is cleared only by reset.
REQ-031 When DIV_SCHED_TICKCNT_EN is undefined, the tick_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Package div_sched_pkg SHALL hold the state enum (IDLE, RUN, PEND) and the constant TICKCNT_W=16.
REQ-033 The WIDTH-bit counter with its wrap/compare logic SHALL be sub-module div_counter, and the FSM and cfg handshake SHALL stay in div_sched.

Verification
REQ-034 Scenario 1: reset, then write D=3 in IDLE, then start -> tick on counter=3 every 4 cycles; clock_out period 8 cycles.
REQ-035 Scenario 2: D=0, then start -> tick high every RUN cycle; clock_out toggles every cycle.
REQ-036 Scenario 3: RUN with D=9, write D=2 at counter=4 -> cfg_ready=0 until the tick at counter=9; subsequent ticks every 3 cycles.
REQ-037 Scenario 4: write accepted on the same cycle as a tick -> one further full old period, then the new period applies.
REQ-038 Scenario 5: in PEND, stop=1 together with start=1 -> next cycle IDLE, busy=0, clock_out=0; pending value is lost, so the next start uses the old D.
REQ-039 Scenario 6: reset_n=0 mid-RUN -> all outputs take their REQ-028 values on the next cycle; with DIV_SCHED_TICKCNT_EN defined, 65536 ticks leave tick_cnt=0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divide-ratio tick scheduler.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam int TICKCNT_W = 16;

endpackage

// File: rtl/div_sched_counter.sv
// Period counter: counts 0..limit while running, wraps, and registers the tick.
module div_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             run_next_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic [WIDTH-1:0] limit_next_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is precomputed from next count and next limit so it lines up with the count it marks.
  always_comb begin
    cnt_d = '0;
    if (run_i && run_next_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
    tick_d = run_next_i && (cnt_d == limit_next_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/div_sched.sv
// Programmable tick/clock divider with queued ratio updates.
// Optional tick counter output enabled by macro DIV_SCHED_TICKCNT_EN.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             clock_out,
  output logic             busy
`ifdef DIV_SCHED_TICKCNT_EN
  , output logic [TICKCNT_W-1:0] tick_cnt
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             cfg_accept;
  logic             tick_w;

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    cfg_accept = cfg_valid && (state_q != PEND);
    unique case (state_q)
      IDLE: begin
        if (cfg_accept) act_d = cfg_div;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          pend_d  = '0;
        end else if (cfg_accept) begin
          pend_d  = cfg_div;
          state_d = PEND;
        end
      end
      PEND: begin
        if (stop) begin
          state_d = IDLE;
          pend_d  = '0;
        end else if (tick_w) begin
          act_d   = pend_q;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    clk_out_d = (state_d == IDLE) ? 1'b0 : (clk_out_q ^ tick_w);
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      act_q     <= '1;
      pend_q    <= '0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
    end
  end

  div_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk_i        (clock_in),
    .rst_ni       (reset_n),
    .run_i        (state_q != IDLE),
    .run_next_i   (state_d != IDLE),
    .limit_i      (act_q),
    .limit_next_i (act_d),
    .tick_o       (tick_w)
  );

  assign tick      = tick_w;
  assign clock_out = clk_out_q;
  assign busy      = (state_q != IDLE);
  assign cfg_ready = (state_q != PEND);

`ifdef DIV_SCHED_TICKCNT_EN
  logic [TICKCNT_W-1:0] tick_cnt_q;

  always_ff @(posedge clock_in) begin
    if (!reset_n) tick_cnt_q <= '0;
    else          tick_cnt_q <= tick_cnt_q + TICKCNT_W'(tick_w);
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule
